// File: rtl/tdc_hit_buffer.sv
// tdc_hit_buffer
//   Sits behind the fine TDC stage. It watches the discriminator level for a
//   new rising edge. One cycle later it samples the TDC's coarse and fine
//   outputs. It then packs a 32-bit hit word and queues that word in a
//   first-word-fall-through FIFO.
//
// Word layout:
//   {ovf, bubble, 2'b00, epoch[7:0], coarse[15:0], fine_bin[3:0]}
//
// Ports:
//   clk, rst     - system clock (shared with the TDC); async active-high reset
//   hit_level    - discriminator level (same net as the TDC signal_in)
//   coarse_time  - TDC coarse timestamp, registered by the TDC on the hit edge
//   fine_time    - TDC thermometer code, registered by the TDC on the hit edge
//   out_valid    - head word present
//   out_ready    - consumer accepts the head word
//   out_data     - head word (zero while empty)
//   fill_level   - words currently stored (0..DEPTH)
//   drop_count   - hits lost to a full FIFO, saturating
module tdc_hit_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hit_level,
  input  logic [15:0]   coarse_time,
  input  logic [7:0]    fine_time,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [AW:0]   fill_level,
  output logic [15:0]   drop_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic [3:0] therm_to_bin(input logic [7:0] t);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, t[i]};
    return n;
  endfunction

  // A clean code has the form 0..01..1, so adding one clears every set bit.
  function automatic logic therm_bubble(input logic [7:0] t);
    return (t & (t + 8'd1)) != 8'd0;
  endfunction

  logic [15:0]   mirror_q, mirror_d;
  logic [7:0]    epoch_q, epoch_d;
  logic          hit_q, hit_d;
  logic          cap_pend_q, cap_pend_d;
  logic [7:0]    epoch_cap_q, epoch_cap_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [15:0]   drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_q [DEPTH];

  logic          rise;
  logic          pop;
  logic          wr_ok;
  logic [31:0]   word_d;

  always_comb begin
    // Edge detect and timebase (cycle N)
    rise        = hit_level & ~hit_q;
    hit_d       = hit_level;
    mirror_d    = mirror_q + 16'd1;
    epoch_d     = (mirror_q == 16'hFFFF) ? epoch_q + 8'd1 : epoch_q;
    cap_pend_d  = rise;
    // The TDC latches its post-edge count, so the epoch must be the post-edge value too.
    epoch_cap_d = rise ? epoch_d : epoch_cap_q;

    // Capture and FIFO write (cycle N+1)
    pop    = out_valid & out_ready;
    wr_ok  = cap_pend_q & ((count_q != FULL_CNT) | pop);
    word_d = {ovf_pend_q, therm_bubble(fine_time), 2'b00, epoch_cap_q,
              coarse_time, therm_to_bin(fine_time)};

    ovf_pend_d = ovf_pend_q;
    drop_d     = drop_q;
    if (wr_ok) begin
      ovf_pend_d = 1'b0;
    end else if (cap_pend_q) begin
      ovf_pend_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mirror_q   <= '0;
      epoch_q    <= '0;
      hit_q      <= 1'b0;
      cap_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mirror_q   <= mirror_d;
      epoch_q    <= epoch_d;
      hit_q      <= hit_d;
      cap_pend_q <= cap_pend_d;
      ovf_pend_q <= ovf_pend_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Data-only storage: contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    epoch_cap_q <= epoch_cap_d;
    if (wr_ok) mem_q[wr_ptr_q] <= word_d;
  end

  // Read side (FWFT head)
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign fill_level = count_q;
  assign drop_count = drop_q;

endmodule
